// File: rtl/wb_regfile.sv
// Write-back latch plus 32x32 register file with two combinational, forwarding read ports.
// Latency: ex result is readable the same cycle, latched at N+1, in the array at N+2; stall only freezes the latch.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              stall,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic              r_wb_we;
    logic [ADDR_W-1:0] r_wb_waddr;
    logic [DATA_W-1:0] r_wb_wdata;
    logic [DATA_W-1:0] w_arr1;
    logic [DATA_W-1:0] w_arr2;

    // Reset outranks commit, so a write pending in the latch is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_wb_we    <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
        end else begin
            if (r_wb_we && (r_wb_waddr != '0)) begin
                r_mem[r_wb_waddr] <= r_wb_wdata;
            end
            if (!stall) begin
                r_wb_we    <= ex_we;
                r_wb_waddr <= ex_waddr;
                r_wb_wdata <= ex_wdata;
            end
        end
    end

    assign wb_we    = r_wb_we;
    assign wb_waddr = r_wb_waddr;
    assign wb_wdata = r_wb_wdata;

    assign w_arr1 = r_mem[raddr1];
    assign w_arr2 = r_mem[raddr2];

    // Youngest producer wins: execute stage, then latch, then array.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic              i_rst,
        input logic              i_re,
        input logic [ADDR_W-1:0] i_raddr,
        input logic              i_ex_we,
        input logic [ADDR_W-1:0] i_ex_waddr,
        input logic [DATA_W-1:0] i_ex_wdata,
        input logic              i_wb_we,
        input logic [ADDR_W-1:0] i_wb_waddr,
        input logic [DATA_W-1:0] i_wb_wdata,
        input logic [DATA_W-1:0] i_arr
    );
        if (i_rst || !i_re) begin
            return '0;
        end else if (i_raddr == '0) begin
            return '0;
        end else if (i_ex_we && (i_ex_waddr == i_raddr)) begin
            return i_ex_wdata;
        end else if (i_wb_we && (i_wb_waddr == i_raddr)) begin
            return i_wb_wdata;
        end
        return i_arr;
    endfunction

    always_comb begin
        rdata1 = read_mux(rst, re1, raddr1, ex_we, ex_waddr, ex_wdata,
                          r_wb_we, r_wb_waddr, r_wb_wdata, w_arr1);
        rdata2 = read_mux(rst, re2, raddr2, ex_we, ex_waddr, ex_wdata,
                          r_wb_we, r_wb_waddr, r_wb_wdata, w_arr2);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an architectural model (newest pending write wins).
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, ex_we, stall, re1, re2;
    logic [AW-1:0] ex_waddr, raddr1, raddr2;
    logic [DW-1:0] ex_wdata;
    logic [DW-1:0] rdata1, rdata2, wb_wdata;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: committed architectural values plus the one pending write.
    logic [DW-1:0] m_mem [32];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .stall(stall),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    function automatic logic [DW-1:0] m_read(input logic re, input logic [AW-1:0] a);
        if (rst || !re || a == 0) return '0;
        if (ex_we && ex_waddr == a) return ex_wdata;
        if (m_we && m_addr == a) return m_data;
        return m_mem[a];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Outputs settle 1ns after inputs change on the falling edge.
    task automatic settle();
        #1;
        chk("rdata1", rdata1, m_read(re1, raddr1));
        chk("rdata2", rdata2, m_read(re2, raddr2));
        chk("wb_we", DW'(wb_we), DW'(m_we));
        chk("wb_waddr", DW'(wb_waddr), DW'(m_addr));
        chk("wb_wdata", wb_wdata, m_data);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (m_we && m_addr != 0) m_mem[m_addr] = m_data;
            if (!stall) begin
                m_we = ex_we; m_addr = ex_waddr; m_data = ex_wdata;
            end
        end
        @(negedge clk);
    endtask

    task automatic ex(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ex_we = we; ex_waddr = a; ex_wdata = d;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; re1 = 1'b0; re2 = 1'b0;
        raddr1 = '0; raddr2 = '0;
        ex(1'b0, '0, '0);
        tick();
        settle(); tick();
        rst = 1'b0;

        // Reset state: every register reads zero on both ports.
        re1 = 1'b1; re2 = 1'b1;
        for (int a = 1; a < 32; a++) begin
            raddr1 = AW'(a); raddr2 = AW'(31 - a + 1);
            settle();
            chk("reset_rd1", rdata1, 32'h0);
            chk("reset_rd2", rdata2, 32'h0);
            chk("reset_wb_we", DW'(wb_we), 32'h0);
            tick();
        end

        // x5 visible via ex forward, latch forward, then array.
        raddr1 = 5; raddr2 = 6;
        ex(1'b1, 5, 32'hDEADBEEF);
        settle(); chk("x5_ex_fwd", rdata1, 32'hDEADBEEF); tick();
        ex(1'b0, 0, 32'h0);
        settle(); chk("x5_wb_fwd", rdata1, 32'hDEADBEEF); chk("x5_wb_we", DW'(wb_we), 32'h1); tick();
        settle(); chk("x5_array", rdata1, 32'hDEADBEEF); tick();

        // Writes to x0 never show.
        raddr1 = 0; raddr2 = 0;
        ex(1'b1, 0, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            settle(); chk("x0_rd1", rdata1, 32'h0); chk("x0_rd2", rdata2, 32'h0); tick();
            ex(1'b0, 0, 32'h0);
        end

        // Back-to-back writes to x7: ex beats wb.
        raddr1 = 7; raddr2 = 7;
        ex(1'b1, 7, 32'h11);
        settle(); chk("x7_n", rdata1, 32'h11); tick();
        ex(1'b1, 7, 32'h22);
        settle(); chk("x7_n1", rdata1, 32'h22); chk("x7_n1_p2", rdata2, 32'h22); tick();
        ex(1'b0, 0, 32'h0);
        settle(); chk("x7_n2", rdata1, 32'h22); tick();
        settle(); chk("x7_n3", rdata1, 32'h22); tick();

        // Stall holds the latch while ex stays forwarded.
        raddr1 = 9; raddr2 = 5;
        stall = 1'b1;
        ex(1'b1, 9, 32'hA5A5A5A5);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stall_rd", rdata1, 32'hA5A5A5A5);
            chk("stall_wb_we", DW'(wb_we), 32'h0);
            tick();
        end
        stall = 1'b0;
        settle(); tick();
        ex(1'b0, 0, 32'h0);
        settle(); chk("stall_wb_cap", wb_wdata, 32'hA5A5A5A5); tick();
        settle(); chk("stall_array", rdata1, 32'hA5A5A5A5); chk("stall_idle_we", DW'(wb_we), 32'h0); tick();

        // Reset discards the pending x3 write.
        raddr1 = 3;
        ex(1'b1, 3, 32'h55);
        settle(); tick();
        ex(1'b0, 0, 32'h0);
        rst = 1'b1;
        settle(); chk("rst_force0", rdata1, 32'h0); tick();
        rst = 1'b0;
        settle(); chk("rst_x3", rdata1, 32'h0); chk("rst_wb_we", DW'(wb_we), 32'h0); tick();
        raddr1 = 5;
        settle(); chk("rst_x5", rdata1, 32'h0); tick();

        // Randomized traffic over a narrow address set to force collisions.
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 20);
            ex_we = ($urandom_range(0, 99) < 70);
            ex_waddr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                   : AW'($urandom_range(0, 5));
            ex_wdata = $urandom;
            re1 = ($urandom_range(0, 99) < 85);
            re2 = ($urandom_range(0, 99) < 85);
            case ($urandom_range(0, 3))
                0:       raddr1 = ex_waddr;
                1:       raddr1 = m_addr;
                default: raddr1 = AW'($urandom_range(0, 5));
            endcase
            raddr2 = ($urandom_range(0, 2) == 0) ? raddr1 : AW'($urandom_range(0, 31));
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
